// File: rtl/y_mat_rd_ctrl_pkg.sv
// Shared types and constants for the Y-matrix index read controller.
package ymat_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } ymat_state_e;

   localparam int unsigned YMA_ENTRY_W = 16;
   localparam int unsigned YMA_ADDR_W  = 11;
   localparam int unsigned YMA_ENTRIES = 16;
   localparam int unsigned YMA_ROW_W   = 16;
   localparam int unsigned YMA_WORD_W  = YMA_ENTRY_W * YMA_ENTRIES;

endpackage

// File: rtl/y_mat_rd_ctrl_if.sv
// Requester, index-memory and response signals of the Y-matrix read controller.
// master: controller side; slave: environment (requesters, memory, consumer).
interface y_mat_rd_ctrl_if #(
   parameter int unsigned MADDR_W = 12
);
   import ymat_pkg::*;

   logic                  req0_valid;
   logic [YMA_ROW_W-1:0]  req0_row;
   logic                  req0_ready;
   logic                  req1_valid;
   logic [YMA_ROW_W-1:0]  req1_row;
   logic                  req1_ready;
   logic                  mem_rd_en;
   logic [MADDR_W-1:0]    mem_rd_addr;
   logic [YMA_WORD_W-1:0] mem_rd_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_id;
   logic [YMA_ROW_W-1:0]  rsp_row;
   logic [YMA_ADDR_W-1:0] rsp_addr;

   modport master (
      input  req0_valid, req0_row, req1_valid, req1_row, mem_rd_data, rsp_ready,
      output req0_ready, req1_ready, mem_rd_en, mem_rd_addr,
             rsp_valid, rsp_id, rsp_row, rsp_addr
   );

   modport slave (
      output req0_valid, req0_row, req1_valid, req1_row, mem_rd_data, rsp_ready,
      input  req0_ready, req1_ready, mem_rd_en, mem_rd_addr,
             rsp_valid, rsp_id, rsp_row, rsp_addr
   );

endinterface

// File: rtl/getYMatAddress.sv
// Selects one 16-bit entry of a 256-bit index word and returns its 11-bit address.
// Entry k sits in bits [255-16k -: 16]; the address is its low 11 bits.
module getYMatAddress
   import ymat_pkg::*;
(
   input  logic                  readEnable,
   input  logic [3:0]            rowEntry,
   input  logic [YMA_WORD_W-1:0] memData,
   output logic [YMA_ADDR_W-1:0] address
);

   // Entry mux; output held at zero when not reading.
   always_comb begin
      address = '0;
      if (readEnable) begin
         for (int unsigned k = 0; k < YMA_ENTRIES; k++) begin
            if (rowEntry == 4'(k)) begin
               address = memData[(YMA_ENTRIES-1-k)*YMA_ENTRY_W +: YMA_ADDR_W];
            end
         end
      end
   end

endmodule

// File: rtl/y_mat_rd_ctrl_rr_arb2.sv
// Two-way round-robin grant with a priority pointer register.
module ymat_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;
   logic ptr_d;

   // Single requester wins outright; a tie goes to the pointer.
   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After an accept the pointer names the requester that was not granted.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i) begin
         ptr_d = ~gnt_o[1];
      end
   end

   // Pointer register, requester 0 first after reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/y_mat_rd_ctrl.sv
// Y-matrix index read controller: arbitrates two row requesters, reads the
// index word row[15:4], extracts entry row[3:0] and returns it with valid/ready.
// Optional macro YMA_RSP_CNT_EN adds rsp_cnt, a wrapping count of completed responses.
module y_mat_rd_ctrl
   import ymat_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned MADDR_W = 12
) (
   input  logic             clock,
   input  logic             reset,
   y_mat_rd_ctrl_if.master  bus,
   output logic             busy
`ifdef YMA_RSP_CNT_EN
   ,
   output logic [15:0]      rsp_cnt
`endif
);

   ymat_state_e           state_q;
   logic [3:0]            cnt_q;
   logic [YMA_ROW_W-1:0]  row_q;
   logic                  id_q;
   logic                  mem_en_q;
   logic [MADDR_W-1:0]    mem_addr_q;
   logic                  rsp_valid_q;
   logic [YMA_ADDR_W-1:0] rsp_addr_q;
   logic                  busy_q;

   logic [1:0]            gnt;
   logic                  accept;
   logic [YMA_ROW_W-1:0]  row_d;
   logic                  sample;
   logic [YMA_ADDR_W-1:0] ext_addr;

   ymat_rr_arb2 u_arb (
      .clk_i    (clock),
      .rst_ni   (reset),
      .req_i    ({bus.req1_valid, bus.req0_valid}),
      .accept_i (accept),
      .gnt_o    (gnt)
   );

   // Ready is gated by reset so no requester sees an accept while reset is held.
   assign accept         = (state_q == IDLE) && reset && (gnt != 2'b00);
   assign bus.req0_ready = accept && gnt[0];
   assign bus.req1_ready = accept && gnt[1];
   assign row_d          = gnt[1] ? bus.req1_row : bus.req0_row;

   assign sample = (state_q == WAIT) && (cnt_q == 4'd1);

   getYMatAddress u_extract (
      .readEnable (sample),
      .rowEntry   (row_q[3:0]),
      .memData    (bus.mem_rd_data),
      .address    (ext_addr)
   );

   // Sequencer: accept, issue one read, wait MEM_LAT, hold response until taken.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         row_q       <= '0;
         id_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  row_q      <= row_d;
                  id_q       <= gnt[1];
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= MADDR_W'(row_d[YMA_ROW_W-1:4]);
                  busy_q     <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en_q <= 1'b0;
               cnt_q    <= 4'(MEM_LAT);
               state_q  <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (sample) begin
                  rsp_addr_q  <= ext_addr;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_rd_en   = mem_en_q;
   assign bus.mem_rd_addr = mem_addr_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_id      = id_q;
   assign bus.rsp_row     = row_q;
   assign bus.rsp_addr    = rsp_addr_q;
   assign busy            = busy_q;

`ifdef YMA_RSP_CNT_EN
   logic [15:0] rsp_cnt_q;

   // Completed-handshake counter, wraps naturally at 16 bits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rsp_cnt_q <= '0;
      end else if (rsp_valid_q && bus.rsp_ready) begin
         rsp_cnt_q <= rsp_cnt_q + 16'd1;
      end
   end

   assign rsp_cnt = rsp_cnt_q;
`endif

endmodule

// File: tb/tb_y_mat_rd_ctrl.sv
// Self-checking bench for y_mat_rd_ctrl: directed cases plus random requests,
// checked against a behavioural memory and round-robin model.
module tb_y_mat_rd_ctrl;
   import ymat_pkg::*;

   localparam int unsigned MEM_LAT = 2;
   localparam int unsigned MADDR_W = 12;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic busy;
`ifdef YMA_RSP_CNT_EN
   logic [15:0] rsp_cnt;
`endif

   y_mat_rd_ctrl_if #(.MADDR_W(MADDR_W)) bus ();

   y_mat_rd_ctrl #(.MEM_LAT(MEM_LAT), .MADDR_W(MADDR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
`ifdef YMA_RSP_CNT_EN
      ,
      .rsp_cnt (rsp_cnt)
`endif
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ptr_m = 0;
   int hs_m = 0;

   always @(posedge clock) cyc <= cyc + 1;

   logic [255:0] mem [int unsigned];

   function automatic logic [255:0] rnd_word();
      logic [255:0] w;
      for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [255:0] get_word(input logic [11:0] a);
      if (!mem.exists(int'(a))) mem[int'(a)] = rnd_word();
      return mem[int'(a)];
   endfunction

   // Reference: split the word into 16 entries, first entry in the top bits.
   function automatic logic [10:0] exp_addr(input logic [15:0] row);
      logic [255:0] w;
      logic [15:0]  ent [16];
      w = get_word(row[15:4]);
      for (int e = 0; e < 16; e++) ent[e] = 16'(w >> (16 * (15 - e)));
      return ent[row[3:0]][10:0];
   endfunction

   // Memory model: word is valid only in the cycle MEM_LAT after the read strobe.
   int due = -1;
   logic [11:0] due_addr = '0;
   always @(posedge clock) begin
      #1;
      if (bus.mem_rd_en === 1'b1) begin
         due      = cyc + int'(MEM_LAT);
         due_addr = bus.mem_rd_addr;
      end
      if (cyc == due) bus.mem_rd_data = get_word(due_addr);
      else            bus.mem_rd_data = rnd_word();
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_mem_en", bus.mem_rd_en, 0);
      chk("rst_mem_addr", bus.mem_rd_addr, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_row", bus.rsp_row, 0);
      chk("rst_rsp_addr", bus.rsp_addr, 0);
      chk("rst_busy", busy, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      tick();
      tick();
      #1;
      chk_reset_outputs();
      reset = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      ptr_m = 0;
      hs_m  = 0;
      tick();
   endtask

   // One full request: grant, read strobe, latency, response fields, stall, handshake.
   task automatic run_req(input bit v0, input bit v1, input logic [15:0] r0,
                          input logic [15:0] r1, input int stall);
      int gid;
      logic [15:0] grow;
      logic [10:0] gaddr;
      int en_extra;
      int rdy_bad;
      bit got;
      gid   = (v0 && v1) ? ptr_m : (v1 ? 1 : 0);
      grow  = (gid == 1) ? r1 : r0;
      gaddr = exp_addr(grow);
      chk("idle_busy", busy, 0);
      bus.req0_valid = v0;
      bus.req0_row   = r0;
      bus.req1_valid = v1;
      bus.req1_row   = r1;
      #1;
      chk("grant0", bus.req0_ready, (gid == 0));
      chk("grant1", bus.req1_ready, (gid == 1));
      ptr_m = 1 - gid;
      tick();
      // Both requesters keep asking while the transaction is in flight.
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_row   = 16'($urandom);
      bus.req1_row   = 16'($urandom);
      #1;
      chk("issue_en", bus.mem_rd_en, 1);
      chk("issue_addr", bus.mem_rd_addr, grow[15:4]);
      chk("issue_busy", busy, 1);
      en_extra = 0;
      rdy_bad  = (bus.req0_ready | bus.req1_ready) ? 1 : 0;
      got = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         tick();
         #1;
         if (bus.mem_rd_en === 1'b1) en_extra++;
         if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) rdy_bad++;
         if (bus.rsp_valid === 1'b1) begin
            got = 1'b1;
            chk("rsp_latency", i, MEM_LAT + 1);
         end
      end
      if (!got) chk("rsp_timeout", bus.rsp_valid, 1);
      chk("single_read", en_extra, 0);
      chk("ready_outside_idle", rdy_bad, 0);
      chk("rsp_id", bus.rsp_id, gid);
      chk("rsp_row", bus.rsp_row, grow);
      chk("rsp_addr", bus.rsp_addr, gaddr);
      for (int s = 0; s < stall; s++) begin
         tick();
         #1;
         chk("stall_valid", bus.rsp_valid, 1);
         chk("stall_addr", bus.rsp_addr, gaddr);
         chk("stall_row", bus.rsp_row, grow);
         chk("stall_mem_en", bus.mem_rd_en, 0);
         chk("stall_ready", {bus.req1_ready, bus.req0_ready}, 0);
      end
      bus.rsp_ready  = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
      bus.rsp_ready = 1'b0;
      hs_m++;
      #1;
      chk("post_hs_valid", bus.rsp_valid, 0);
      chk("post_hs_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] w;
      logic [15:0]  ra, rb;
      bit v0, v1;
      bus.req0_valid  = 1'b0;
      bus.req1_valid  = 1'b0;
      bus.req0_row    = '0;
      bus.req1_row    = '0;
      bus.rsp_ready   = 1'b0;
      bus.mem_rd_data = '0;

      do_reset();

      // Single request, entry 3 of word 1.
      w = rnd_word();
      w[202:192] = 11'h2A5;
      mem[1] = w;
      run_req(1'b1, 1'b0, 16'h0013, 16'($urandom), 0);
      chk("dir_2a5", bus.rsp_addr, 11'h2A5);

      // Simultaneous requests from a fresh reset: 0, 1, then 0 again.
      do_reset();
      run_req(1'b1, 1'b1, 16'($urandom), 16'($urandom), 0);
      run_req(1'b1, 1'b1, 16'($urandom), 16'($urandom), 0);
      run_req(1'b1, 1'b1, 16'($urandom), 16'($urandom), 0);

      // Backpressure.
      run_req(1'b1, 1'b0, 16'($urandom), 16'($urandom), 5);

      // Boundary entries.
      w = rnd_word();
      w[10:0] = 11'h7FF;
      mem[12'hFFF] = w;
      run_req(1'b0, 1'b1, 16'($urandom), 16'hFFFF, 0);
      chk("dir_7ff", bus.rsp_addr, 11'h7FF);
      w = rnd_word();
      w[250:240] = 11'h001;
      mem[0] = w;
      run_req(1'b1, 1'b0, 16'h0000, 16'($urandom), 0);
      chk("dir_001", bus.rsp_addr, 11'h001);

      // Reset while waiting on memory.
      bus.req0_valid = 1'b1;
      bus.req0_row   = 16'($urandom);
      tick();
      bus.req0_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      #1;
      chk_reset_outputs();
      reset = 1'b1;
      ptr_m = 0;
      hs_m  = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         #1;
         chk("stale_rsp_valid", bus.rsp_valid, 0);
         chk("stale_mem_en", bus.mem_rd_en, 0);
      end
      run_req(1'b1, 1'b0, 16'h0020, 16'($urandom), 0);

      // Random traffic against the model.
      for (int n = 0; n < 24; n++) begin
         v0 = 1'($urandom);
         v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1'b1;
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_req(v0, v1, ra, rb, int'($urandom_range(0, 3)));
      end

`ifdef YMA_RSP_CNT_EN
      chk("rsp_cnt", rsp_cnt, hs_m);
      reset = 1'b0;
      tick();
      #1;
      chk("rsp_cnt_reset", rsp_cnt, 0);
      reset = 1'b1;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/y_mat_rd_ctrl.md
Name: y_mat_rd_ctrl

Overview:
- Sequencer that shares the Y-matrix index memory between two requesters and returns the 11-bit row address for a requested row.
- Arbitrates requests round-robin, issues one 256-bit index-memory read per request at word row[15:4], and waits the fixed memory latency.
- Extracts entry row[3:0] through getYMatAddress and returns the address with a valid/ready handshake.
- Sits between the row-scheduling logic (two requester ports) and the index SRAM.

Parameters:
MEM_LAT, 2, cycles from the mem_rd_en cycle to the mem_rd_data-valid cycle; legal range 1..15.
MADDR_W, 12, index memory word address width; equals 16-4 for 16 entries per word.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  synchronous, active-low reset.
req0_valid  in  1  requester 0 has a row.
req0_row  in  16  row number, requester 0.
req0_ready  out  1  requester 0 accepted this cycle.
req1_valid  in  1  requester 1 has a row.
req1_row  in  16  row number, requester 1.
req1_ready  out  1  requester 1 accepted this cycle.
mem_rd_en  out  1  index memory read strobe.
mem_rd_addr  out  MADDR_W  index memory word address.
mem_rd_data  in  256  index memory read word; 16 entries of 16 bits, entry k in bits [255-16k -: 16], address in the low 11 bits.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer takes response.
rsp_id  out  1  requester that owns the response.
rsp_row  out  16  echoed row number.
rsp_addr  out  11  extracted row address.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: reset sampled low at a clock edge forces the following:
  - State goes to IDLE and the wait counter clears.
  - Priority pointer is set to requester 0.
  - All outputs are driven to 0: ready, mem_rd_en, mem_rd_addr, rsp_*, busy.
- Reset mid-operation abandons the transaction. Memory data arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester. When both are valid, grant the one named by the priority pointer.
  - The granted reqN_ready is high combinationally in this cycle only; the other ready stays 0.
  - Latch row and id, toggle the pointer to the other requester, then go to ISSUE.
  - No valid requests: stay in IDLE.
  - Ready is never high outside IDLE.
- ISSUE:
  - mem_rd_en=1 for exactly one cycle, mem_rd_addr=latched row[15:4].
  - Load the counter with MEM_LAT, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, sample mem_rd_data and drive getYMatAddress with readEnable=1 and row=latched row.
  - Register its output into rsp_addr, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_row and rsp_addr are held stable.
  - On rsp_ready=1, go to IDLE; rsp_valid drops next cycle.
  - rsp_ready low: stay in RESP with no timeout.
- Latency: accept at cycle T gives mem_rd_en at T+1, data sampled at T+1+MEM_LAT, and rsp_valid at T+2+MEM_LAT.
  - The next accept is possible no earlier than the cycle after the response handshake.
  - Minimum period per request is MEM_LAT+3.
- Single outstanding read. mem_rd_en is never asserted twice for one request.
- Requester dropping valid before ready: treated as no request, no error.
- Row upper bits: all 16 bits are used; row 16'hFFFF reads word 12'hFFF, entry 15, bits [10:0].

Optional Feature:
- Macro: YMA_RSP_CNT_EN.
- When defined: adds output rsp_cnt [15:0], which counts completed handshakes (rsp_valid&rsp_ready).
  - Resets to 0 and wraps 16'hFFFF to 16'h0000.
- When undefined: port and counter are absent.

Decomposition:
- Shared package ymat_pkg holds:
  - State enum with IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Constants YMA_ENTRY_W=16, YMA_ADDR_W=11, YMA_ENTRIES=16.
- Instantiate the existing getYMatAddress for extraction.
- One new sub-module is natural: ymat_rr_arb2, a two-way round-robin grant plus pointer register.

Test Plan:
- Single request, MEM_LAT=2:
  - Stimulus: req0_row=16'h0013; memory word 12'h001 has bits [202:192]=11'h2A5.
  - Expected: mem_rd_addr=12'h001 at T+1, rsp_valid at T+4, rsp_addr=11'h2A5, rsp_id=0, rsp_row=16'h0013.
- Simultaneous requests:
  - Stimulus: req0 and req1 valid after reset, rsp_ready always high.
  - Expected: req0 granted first, req1 next.
  - Then req0 and req1 both valid again: req0 is granted.
- Backpressure:
  - Stimulus: rsp_ready held low 5 cycles.
  - Expected: rsp_valid and rsp_addr stable; no req ready and no mem_rd_en during the stall; IDLE the cycle after rsp_ready=1.
- Boundary entry:
  - Stimulus: req1_row=16'hFFFF with word 12'hFFF bits [10:0]=11'h7FF.
  - Expected: rsp_addr=11'h7FF, rsp_id=1.
  - Stimulus: req0_row=16'h0000 with bits [250:240]=11'h001.
  - Expected: rsp_addr=11'h001.
- Reset mid-operation:
  - Stimulus: assert reset low during WAIT, release, then apply new req0_row=16'h0020.
  - Expected: outputs 0 after reset; the stale read produces no rsp_valid; the new request completes normally.
- With YMA_RSP_CNT_EN:
  - Stimulus: 3 completed handshakes.
  - Expected: rsp_cnt=3; reset returns it to 0.
